// File: rtl/period_meter.sv
// Measures the period of a slow square wave in clkin cycles.
// Reports it as a saturating two-digit BCD value with a stall timeout.
module period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic       clkin,
  input  logic       clr,
  input  logic       sig_in,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo,
  output logic       valid,
  output logic       ovf,
  output logic       stalled,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT <= 99) begin : g_bad_tmo
    $error("TIMEOUT must be greater than 99");
  end

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic s;
  logic s_d;
  logic rise;

  logic [3:0]    cnt_hi, cnt_hi_nx;
  logic [3:0]    cnt_lo, cnt_lo_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          ovf_run, ovf_run_nx;
  logic [3:0]    digit_hi_nx;
  logic [3:0]    digit_lo_nx;
  logic          valid_nx;
  logic          ovf_nx;
  logic          stalled_nx;

  always_ff @(posedge clkin) begin
    if (clr) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d  <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign busy = (state == MEASURE);

  always_ff @(posedge clkin) begin
    if (clr) begin
      state    <= IDLE;
      cnt_hi   <= 4'd0;
      cnt_lo   <= 4'd1;
      tmo      <= '0;
      ovf_run  <= 1'b0;
      digit_hi <= 4'd0;
      digit_lo <= 4'd0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt_hi   <= cnt_hi_nx;
      cnt_lo   <= cnt_lo_nx;
      tmo      <= tmo_nx;
      ovf_run  <= ovf_run_nx;
      digit_hi <= digit_hi_nx;
      digit_lo <= digit_lo_nx;
      valid    <= valid_nx;
      ovf      <= ovf_nx;
      stalled  <= stalled_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_hi_nx   = cnt_hi;
    cnt_lo_nx   = cnt_lo;
    tmo_nx      = tmo;
    ovf_run_nx  = ovf_run;
    digit_hi_nx = digit_hi;
    digit_lo_nx = digit_lo;
    valid_nx    = 1'b0;
    ovf_nx      = ovf;
    stalled_nx  = stalled;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx   = MEASURE;
          cnt_hi_nx  = 4'd0;
          cnt_lo_nx  = 4'd1;
          tmo_nx     = '0;
          ovf_run_nx = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          digit_hi_nx = cnt_hi;
          digit_lo_nx = cnt_lo;
          ovf_nx      = ovf_run;
          valid_nx    = 1'b1;
          stalled_nx  = 1'b0;
          cnt_hi_nx   = 4'd0;
          cnt_lo_nx   = 4'd1;
          ovf_run_nx  = 1'b0;
          tmo_nx      = '0;
        end else begin
          tmo_nx = tmo + TW'(1);
          // saturate at 99 and remember that the period overflowed
          if (cnt_hi == 4'd9 && cnt_lo == 4'd9) begin
            ovf_run_nx = 1'b1;
          end else if (cnt_lo == 4'd9) begin
            cnt_lo_nx = 4'd0;
            cnt_hi_nx = cnt_hi + 4'd1;
          end else begin
            cnt_lo_nx = cnt_lo + 4'd1;
          end
          if (tmo == TMO_LAST) begin
            state_nx   = IDLE;
            stalled_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
